cordic_vectoring: RTL and testbench
===================================

Name: cordic_vectoring

Overview:
Iterative CORDIC in vectoring mode. It is the inverse of the rotation-mode sin/cos engine: it takes a Cartesian pair (x, y) and returns the angle atan2(y, x) and the magnitude sqrt(x²+y²). It uses the same angle quantisation and the same level valid/ack handshake style. It sits between the sample front-end and the result converter, and computes one vector per request.

Parameters:
WIDTH, 16, width of x_in, y_in, angle_out, mag_out; fixed at 16 (arctan table has 16 entries)
ITER, 16, number of micro-rotations, 1..16

Ports:
clk  input  1  clock
rst  input  1  reset; asynchronous, active-high
valid_in  input  1  request level; x_in/y_in valid while high
x_in  input  WIDTH  signed x component, two's complement
y_in  input  WIDTH  signed y component, two's complement
angle_out  output  WIDTH  signed angle; 0x4000 = 45°, 0x2000 = 22.5°; saturated to [0x8000, 0x7FFF] = [-90°, +90°)
half_out  output  1  1 = add 180° to angle_out (input had x < 0)
mag_out  output  WIDTH  unsigned magnitude, gain-compensated
valid_out  output  1  results valid
in_ack  output  1  one-cycle pulse: inputs captured

Behaviour:
- Reset (async): state = IDLE; angle_out, half_out, mag_out, valid_out, in_ack = 0; internal x/y/z/i = 0. Reset mid-computation aborts the operation; no result is produced.
- Internal datapath: x and y are WIDTH+2 signed (covers mirroring of -32768 and CORDIC gain up to about 76k). z is WIDTH+2 signed.
- Arctan table: same constants as the rotation engine: 4000, 25C8, 13F6, 0A22, 0516, 028B, 0145, 00A2, 0051, 0029, 0014, 000A, 0005, 0003, 0002, 0001 (hex).
- State IDLE:
  - valid_out = 0.
  - If valid_in = 1: latch x_in and y_in, set in_ack = 1.
  - Special cases go to DONE; all other inputs go to PRE.
  - Special case (0, 0): angle = 0, mag = 0, half = 0.
  - Special case x = 0, y > 0: angle = 0x7FFF, mag = y, half = 0.
  - Special case x = 0, y < 0: angle = 0x8000, mag = -y, half = 0.
- State PRE:
  - in_ack = 0.
  - If x < 0: x = -x, y = -y, half = 1; otherwise half = 0.
  - z = 0, i = 0, go to ITER.
- State ITER (one micro-rotation per clock):
  - If y >= 0: x += y>>>i, y -= x>>>i, z += atan[i].
  - If y < 0: x -= y>>>i, y += x>>>i, z -= atan[i].
  - Right-hand sides use the pre-update values. Shifts are arithmetic.
  - i++; when i = ITER-1 is processed, go to SCALE.
- State SCALE (registered into the output registers):
  - mag_out = (x × 0x4DBA) >>> 15, truncated. Saturate to 0xFFFF if the result exceeds it (unreachable for legal inputs).
  - angle_out = z saturated to 16-bit signed.
  - half_out = half.
  - Go to DONE.
- Output registers change only in SCALE or in IDLE special-case capture. During computation the previous results are held.
- State DONE:
  - valid_out = 1, in_ack = 0.
  - If valid_in = 0: go to IDLE and clear valid_out on the same edge. Otherwise hold; outputs stay stable.
- Latency, counted from the capture edge E0:
  - Normal path: valid_out high after edge E0 + ITER + 3 (19 cycles for ITER = 16).
  - Special case: valid_out high after edge E0 + 1.
- Input rules:
  - x_in and y_in changes after capture are ignored.
  - valid_in dropping during PRE/ITER/SCALE does not abort. DONE is entered, valid_out pulses for one cycle, then the block returns to IDLE.
- Back-to-back requests: valid_in held high after DONE→IDLE causes a new capture in IDLE. A new request is only accepted in IDLE.
- Accuracy (ITER = 16): angle within ±3 LSB, magnitude within ±4 LSB of ideal.

Test Plan:
- Reset asserted mid-ITER -> all outputs 0 immediately (async); state IDLE; next valid_in produces a fresh, correct result.
- x = 0x4000, y = 0x4000, valid_in held -> in_ack pulses one cycle at E0; valid_out rises after edge E0+19; angle_out = 0x4000 ±3, mag_out = 0x5A82 ±4, half_out = 0; outputs stable while valid_in high; valid_out = 0 on the edge after valid_in falls.
- x = 0x7000, y = 0 -> angle_out = 0x0000 ±3, mag_out = 0x7000 ±4, half_out = 0.
- x = -0x4000, y = -0x4000 -> half_out = 1, angle_out = 0x4000 ±3 (225°), mag_out = 0x5A82 ±4; x = -0x8000, y = 0 -> half_out = 1, angle ≈ 0, mag_out = 0x8000 ±4.
- Special cases: (0, 0) -> valid_out after edge E0+1, all results 0. (0, 0x1234) -> angle_out = 0x7FFF, mag_out = 0x1234. (0, -0x1234) -> angle_out = 0x8000, mag_out = 0x1234.
- valid_in dropped after capture, with x_in/y_in changed during ITER -> result still matches the latched inputs; valid_out high exactly one cycle; a second request then completes normally.

Source files
------------

// File: rtl/cordic_vectoring.sv
`default_nettype none
// ============================================================================
//  Module      : cordic_vectoring
//  Description : Iterative vectoring-mode CORDIC; returns atan2(y, x) and the
//                gain-compensated magnitude of a Cartesian pair.
//  Revision    : 1.0 - initial release
// ============================================================================
module cordic_vectoring #(
    parameter int WIDTH = 16,
    parameter int ITER  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] x_in,
    input  logic [WIDTH-1:0] y_in,
    output logic [WIDTH-1:0] angle_out,
    output logic             half_out,
    output logic [WIDTH-1:0] mag_out,
    output logic             valid_out,
    output logic             in_ack
);

    localparam int DW = WIDTH + 2;
    localparam int PW = DW + 17;

    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_pre   = 3'd1;
    localparam logic [2:0] c_st_iter  = 3'd2;
    localparam logic [2:0] c_st_scale = 3'd3;
    localparam logic [2:0] c_st_done  = 3'd4;

    localparam logic [3:0]  c_last_iter = 4'(ITER - 1);
    localparam logic [15:0] c_gain_inv  = 16'h4DBA;

    logic [2:0]           r_state;
    logic [2:0]           w_next;
    logic signed [DW-1:0] r_x;
    logic signed [DW-1:0] r_y;
    logic signed [DW-1:0] r_z;
    logic [3:0]           r_i;
    logic                 r_half;

    logic signed [DW-1:0] w_xs;
    logic signed [DW-1:0] w_ys;
    logic signed [DW-1:0] w_atan;
    logic                 w_xzero;
    logic [WIDTH-1:0]     w_yabs;
    logic [WIDTH-1:0]     w_special_angle;
    logic signed [PW-1:0] w_prod;
    logic signed [PW-1:0] w_mag_full;
    logic [WIDTH-1:0]     w_mag_sat;
    logic [WIDTH-1:0]     w_angle_sat;

    function automatic logic [15:0] atan_lut(input logic [3:0] idx);
        case (idx)
            4'd0:    atan_lut = 16'h4000;
            4'd1:    atan_lut = 16'h25C8;
            4'd2:    atan_lut = 16'h13F6;
            4'd3:    atan_lut = 16'h0A22;
            4'd4:    atan_lut = 16'h0516;
            4'd5:    atan_lut = 16'h028B;
            4'd6:    atan_lut = 16'h0145;
            4'd7:    atan_lut = 16'h00A2;
            4'd8:    atan_lut = 16'h0051;
            4'd9:    atan_lut = 16'h0029;
            4'd10:   atan_lut = 16'h0014;
            4'd11:   atan_lut = 16'h000A;
            4'd12:   atan_lut = 16'h0005;
            4'd13:   atan_lut = 16'h0003;
            4'd14:   atan_lut = 16'h0002;
            default: atan_lut = 16'h0001;
        endcase
    endfunction

    assign w_xs   = r_x >>> r_i;
    assign w_ys   = r_y >>> r_i;
    assign w_atan = $signed({2'b00, atan_lut(r_i)});

    // x = 0 is resolved at capture time: the angle is on an axis and |y| is exact
    assign w_xzero         = (x_in == '0);
    assign w_yabs          = y_in[WIDTH-1] ? (~y_in + 1'b1) : y_in;
    assign w_special_angle = (y_in == '0)    ? '0 :
                             y_in[WIDTH-1]   ? {1'b1, {(WIDTH-1){1'b0}}} :
                                               {1'b0, {(WIDTH-1){1'b1}}};

    assign w_prod     = r_x * $signed({1'b0, c_gain_inv});
    assign w_mag_full = w_prod >>> 15;
    assign w_mag_sat  = w_mag_full[PW-1]          ? '0 :
                        (|w_mag_full[PW-2:WIDTH]) ? '1 : w_mag_full[WIDTH-1:0];
    assign w_angle_sat = (&r_z[DW-1:WIDTH-1] || ~|r_z[DW-1:WIDTH-1]) ? r_z[WIDTH-1:0] :
                         r_z[DW-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= c_st_idle;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_st_idle:  if (valid_in) w_next = w_xzero ? c_st_done : c_st_pre;
            c_st_pre:   w_next = c_st_iter;
            c_st_iter:  if (r_i == c_last_iter) w_next = c_st_scale;
            c_st_scale: w_next = c_st_done;
            // DONE always shows valid_out for at least one cycle before releasing
            c_st_done:  if (valid_out && !valid_in) w_next = c_st_idle;
            default:    w_next = c_st_idle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x       <= '0;
            r_y       <= '0;
            r_z       <= '0;
            r_i       <= '0;
            r_half    <= 1'b0;
            angle_out <= '0;
            half_out  <= 1'b0;
            mag_out   <= '0;
            valid_out <= 1'b0;
            in_ack    <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    valid_out <= 1'b0;
                    in_ack    <= valid_in;
                    if (valid_in) begin
                        r_x <= DW'($signed(x_in));
                        r_y <= DW'($signed(y_in));
                        if (w_xzero) begin
                            angle_out <= w_special_angle;
                            mag_out   <= w_yabs;
                            half_out  <= 1'b0;
                        end
                    end
                end
                c_st_pre: begin
                    in_ack <= 1'b0;
                    r_z    <= '0;
                    r_i    <= '0;
                    r_half <= r_x[DW-1];
                    if (r_x[DW-1]) begin
                        r_x <= -r_x;
                        r_y <= -r_y;
                    end
                end
                c_st_iter: begin
                    if (!r_y[DW-1]) begin
                        r_x <= r_x + w_ys;
                        r_y <= r_y - w_xs;
                        r_z <= r_z + w_atan;
                    end else begin
                        r_x <= r_x - w_ys;
                        r_y <= r_y + w_xs;
                        r_z <= r_z - w_atan;
                    end
                    r_i <= r_i + 4'd1;
                end
                c_st_scale: begin
                    mag_out   <= w_mag_sat;
                    angle_out <= w_angle_sat;
                    half_out  <= r_half;
                end
                c_st_done: begin
                    in_ack <= 1'b0;
                    if (!valid_out)     valid_out <= 1'b1;
                    else if (!valid_in) valid_out <= 1'b0;
                end
                default: begin
                    valid_out <= 1'b0;
                    in_ack    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cordic_vectoring.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cordic_vectoring
//  Description : Randomised and directed bench for cordic_vectoring against a
//                real-arithmetic atan2/hypot reference.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cordic_vectoring;

    localparam int    ITER         = 16;
    localparam real   c_lsb_per_rad = 65536.0 / 3.14159265358979323846;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in;
    logic [15:0] x_in;
    logic [15:0] y_in;
    logic [15:0] angle_out;
    logic        half_out;
    logic [15:0] mag_out;
    logic        valid_out;
    logic        in_ack;

    int n_cmp = 0;
    int n_bad = 0;

    cordic_vectoring #(.WIDTH(16), .ITER(ITER)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .valid_in  (valid_in),
        .x_in      (x_in),
        .y_in      (y_in),
        .angle_out (angle_out),
        .half_out  (half_out),
        .mag_out   (mag_out),
        .valid_out (valid_out),
        .in_ack    (in_ack)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int obs, input int exp, input int tol);
        int d;
        n_cmp++;
        d = obs - exp;
        if (d < 0) d = -d;
        if (d > tol) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (tol %0d)", tag, obs, exp, tol);
        end
    endtask

    function automatic int abs16(input logic [15:0] a);
        int v;
        v = int'($signed(a));
        return (v < 0) ? -v : v;
    endfunction

    // Ideal result: axis cases are exact, otherwise fold into the right half-plane
    task automatic ref_model(input logic [15:0] x, input logic [15:0] y,
                             output int ang, output int mag, output int half, output bit special);
        real xr, yr, a;
        int  xi, yi;
        xi = int'($signed(x));
        yi = int'($signed(y));
        if (xi == 0) begin
            special = 1'b1;
            half    = 0;
            mag     = (yi < 0) ? -yi : yi;
            ang     = (yi == 0) ? 0 : (yi > 0) ? 32767 : -32768;
        end else begin
            special = 1'b0;
            half    = (xi < 0) ? 1 : 0;
            xr = real'(xi);
            yr = real'(yi);
            if (half == 1) begin
                xr = -xr;
                yr = -yr;
            end
            a   = $atan2(yr, xr) * c_lsb_per_rad;
            ang = int'(a);
            if (ang > 32767)  ang = 32767;
            if (ang < -32768) ang = -32768;
            mag = int'($sqrt(xr * xr + yr * yr));
        end
    endtask

    task automatic run_vec(input logic [15:0] x, input logic [15:0] y, input bit drop,
                           input int atol, input int mtol, input string tag);
        int ang, mag, half, n;
        bit sp;
        ref_model(x, y, ang, mag, half, sp);
        @(negedge clk);
        valid_in = 1'b1;
        x_in     = x;
        y_in     = y;
        @(posedge clk); #1;
        check_val({tag, ".ack"}, int'(in_ack), 1, 0);
        @(negedge clk);
        if (drop) begin
            valid_in = 1'b0;
            x_in     = ~x;
            y_in     = x ^ 16'h5A5A;
        end
        n = 0;
        while (!valid_out && n < 100) begin
            @(posedge clk); #1;
            n++;
            if (n == 1) check_val({tag, ".ack_pulse"}, int'(in_ack), 0, 0);
        end
        check_val({tag, ".latency"}, n, sp ? 1 : ITER + 3, 0);
        check_val({tag, ".angle"}, int'($signed(angle_out)), ang, sp ? 0 : atol);
        check_val({tag, ".mag"},   int'(mag_out), mag, sp ? 0 : mtol);
        check_val({tag, ".half"},  int'(half_out), half, 0);
        if (!drop) begin
            repeat (3) begin
                @(negedge clk);
                x_in = 16'($urandom);
                y_in = 16'($urandom);
            end
            @(posedge clk); #1;
            check_val({tag, ".hold_valid"}, int'(valid_out), 1, 0);
            check_val({tag, ".hold_angle"}, int'($signed(angle_out)), ang, sp ? 0 : atol);
            check_val({tag, ".hold_mag"},   int'(mag_out), mag, sp ? 0 : mtol);
            @(negedge clk);
            valid_in = 1'b0;
        end
        @(posedge clk); #1;
        check_val({tag, ".valid_drop"}, int'(valid_out), 0, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] rx, ry;
        rst      = 1'b1;
        valid_in = 1'b0;
        x_in     = '0;
        y_in     = '0;
        #12;
        check_val("rst.angle", int'(angle_out), 0, 0);
        check_val("rst.mag",   int'(mag_out),   0, 0);
        check_val("rst.half",  int'(half_out),  0, 0);
        check_val("rst.valid", int'(valid_out), 0, 0);
        check_val("rst.ack",   int'(in_ack),    0, 0);
        @(negedge clk);
        rst = 1'b0;

        run_vec(16'h4000, 16'h4000, 1'b0, 3, 4, "q45");
        run_vec(16'h7000, 16'h0000, 1'b0, 3, 4, "xaxis");
        run_vec(16'hC000, 16'hC000, 1'b0, 3, 4, "q225");
        run_vec(16'h8000, 16'h0000, 1'b0, 3, 4, "xmin");
        run_vec(16'h0000, 16'h0000, 1'b0, 0, 0, "zero");
        run_vec(16'h0000, 16'h1234, 1'b0, 0, 0, "ypos");
        run_vec(16'h0000, 16'hEDCC, 1'b0, 0, 0, "yneg");
        run_vec(16'h3000, 16'hE000, 1'b1, 3, 4, "drop");
        run_vec(16'h5000, 16'h2000, 1'b0, 3, 4, "after_drop");
        run_vec(16'h0000, 16'h7FFF, 1'b1, 0, 0, "drop_sp");

        // Truncation error grows as the vector shrinks, so random vectors keep
        // at least one component at quarter scale or above.
        for (int k = 0; k < 30; k++) begin
            do begin
                rx = 16'($urandom);
                ry = 16'($urandom);
            end while (abs16(rx) < 16384 && abs16(ry) < 16384);
            run_vec(rx, ry, (k % 3) == 0, 12, 8, $sformatf("rnd%0d", k));
        end

        @(negedge clk);
        valid_in = 1'b1;
        x_in     = 16'h2345;
        y_in     = 16'h6789;
        repeat (8) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_val("midrst.angle", int'(angle_out), 0, 0);
        check_val("midrst.mag",   int'(mag_out),   0, 0);
        check_val("midrst.half",  int'(half_out),  0, 0);
        check_val("midrst.valid", int'(valid_out), 0, 0);
        check_val("midrst.ack",   int'(in_ack),    0, 0);
        valid_in = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("midrst.idle_valid", int'(valid_out), 0, 0);
        run_vec(16'hB000, 16'h3000, 1'b0, 3, 4, "post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
